input_conditioner: RTL and testbench

//   Parametrised conditioner for active-low switch/sensor inputs (nMode, nTrip, nFork, nCrank, ...).
//   Per channel: N-stage synchroniser, counter-based debounce, press/release edge pulses.

---
 rtl/input_conditioner.sv | 95 +++++++++
 tb/tb_input_conditioner.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Conditioner for active-low switch/sensor pads: synchroniser, counter debounce, press/release pulses.
// Define LONG_PRESS_EN to build the per-channel hold counters that drive LongPress.
module input_conditioner #(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DB_COUNT    = 4,
   parameter int LONG_CYCLES = 1024
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic [NUM_CH-1:0] nIn,
   output logic [NUM_CH-1:0] Level,
   output logic [NUM_CH-1:0] Press,
   output logic [NUM_CH-1:0] Release,
   output logic [NUM_CH-1:0] LongPress
);

   localparam int CW = $clog2(DB_COUNT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

   genvar i;
   for (i = 0; i < NUM_CH; i++) begin : gCh
      logic [SYNC_STAGES-1:0] syncReg;
      logic [CW-1:0]          cnt;
      logic                   synced;
      logic                   levelReg;
      logic                   pressReg;
      logic                   releaseReg;

      assign synced     = ~syncReg[SYNC_STAGES-1];
      assign Level[i]   = levelReg;
      assign Press[i]   = pressReg;
      assign Release[i] = releaseReg;

      // Sync flops preset to the pull-up level; any bounce back to Level discards all progress
      always_ff @(posedge Clock or negedge nReset) begin
         if (!nReset) begin
            syncReg    <= '1;
            cnt        <= '0;
            levelReg   <= 1'b0;
            pressReg   <= 1'b0;
            releaseReg <= 1'b0;
         end else begin
            syncReg    <= {syncReg[SYNC_STAGES-2:0], nIn[i]};
            pressReg   <= 1'b0;
            releaseReg <= 1'b0;
            if (synced == levelReg) begin
               cnt <= '0;
            end else if (cnt >= CNT_LAST) begin
               cnt        <= '0;
               levelReg   <= synced;
               pressReg   <= synced;
               releaseReg <= ~synced;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end

`ifdef LONG_PRESS_EN
      localparam int HW = $clog2(LONG_CYCLES + 1);
      localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
      localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

      logic [HW-1:0] hold;
      logic          longReg;

      assign LongPress[i] = longReg;

      // Hold saturates at LONG_CYCLES so a single press yields exactly one LongPress pulse
      always_ff @(posedge Clock or negedge nReset) begin
         if (!nReset) begin
            hold    <= '0;
            longReg <= 1'b0;
         end else begin
            longReg <= 1'b0;
            if (!levelReg) begin
               hold <= '0;
            end else if (hold < HOLD_MAX) begin
               hold    <= hold + 1'b1;
               longReg <= (hold == HOLD_LAST);
            end
         end
      end
`else
      // LONG_CYCLES has no effect in this build; both arms tie the pulse off
      if (LONG_CYCLES > 0) begin : gLongTie
         assign LongPress[i] = 1'b0;
      end else begin : gLongTieAlt
         assign LongPress[i] = 1'b0;
      end
`endif
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner (NUM_CH=4, SYNC_STAGES=2, DB_COUNT=4, LONG_CYCLES=16).
module tb_input_conditioner;

   logic       Clock;
   logic       nReset;
   logic [3:0] nIn;
   logic [3:0] Level;
   logic [3:0] Press;
   logic [3:0] Release;
   logic [3:0] LongPress;

   int checkCount = 0;
   int errorCount = 0;
   logic sawLong  = 1'b0;

   input_conditioner #(
      .NUM_CH(4),
      .SYNC_STAGES(2),
      .DB_COUNT(4),
      .LONG_CYCLES(16)
   ) dut (
      .Clock(Clock),
      .nReset(nReset),
      .nIn(nIn),
      .Level(Level),
      .Press(Press),
      .Release(Release),
      .LongPress(LongPress)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // One rising edge, then settle so outputs are sampled away from the edge
   task automatic stepClock(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge Clock);
         #1;
         if (LongPress != 4'b0000) sawLong = 1'b1;
      end
   endtask

   task automatic applyStimulus(input logic [3:0] nInVal);
      nIn = nInVal;
   endtask

   initial begin
      int pressTick;
      int pressCount;
      int longTick;
      int longCount;
      int bouncePress;
      logic pat [20];

      nReset = 1'b0;
      applyStimulus(4'b0000);
      stepClock(3);
      checkOutput("rstLevel", 32'(Level), 32'h0);
      checkOutput("rstPress", 32'(Press), 32'h0);
      checkOutput("rstRelease", 32'(Release), 32'h0);
      checkOutput("rstLong", 32'(LongPress), 32'h0);

      applyStimulus(4'b1111);
      nReset = 1'b1;
      stepClock(4);
      checkOutput("idleLevel", 32'(Level), 32'h0);

      // Clean press on ch0: Level registered on the 6th edge after nIn changes
      applyStimulus(4'b1110);
      stepClock(5);
      checkOutput("ch0PressEarly", 32'(Level), 32'h0);
      checkOutput("ch0PressEarlyP", 32'(Press), 32'h0);
      stepClock(1);
      checkOutput("ch0Level", 32'(Level), 32'h1);
      checkOutput("ch0Press", 32'(Press), 32'h1);
      checkOutput("ch0NoRel", 32'(Release), 32'h0);
      stepClock(1);
      checkOutput("ch0PressOne", 32'(Press), 32'h0);
      checkOutput("ch0LevelHeld", 32'(Level), 32'h1);
      stepClock(13);
      applyStimulus(4'b1111);
      stepClock(5);
      checkOutput("ch0RelEarly", 32'(Level), 32'h1);
      stepClock(1);
      checkOutput("ch0RelLevel", 32'(Level), 32'h0);
      checkOutput("ch0Release", 32'(Release), 32'h1);
      checkOutput("ch0RelNoPress", 32'(Press), 32'h0);
      stepClock(1);
      checkOutput("ch0RelOne", 32'(Release), 32'h0);

      // Bounce on ch2: 3 low, 1 high, 3 low, 1 high, then steady low
      for (int j = 0; j < 20; j++) pat[j] = 1'b0;
      pat[3] = 1'b1;
      pat[7] = 1'b1;
      pressTick   = -1;
      pressCount  = 0;
      bouncePress = 0;
      for (int j = 0; j < 20; j++) begin
         applyStimulus({1'b1, pat[j], 2'b11});
         stepClock(1);
         if (Press[2]) begin
            pressCount++;
            if (pressTick < 0) pressTick = j;
         end
         if (j < 13 && (Level[2] || Press != 4'b0000)) bouncePress++;
      end
      checkOutput("bounceQuiet", 32'(bouncePress), 32'd0);
      checkOutput("bouncePressCnt", 32'(pressCount), 32'd1);
      checkOutput("bouncePressTick", 32'(pressTick), 32'd13);
      checkOutput("bounceLevel", 32'(Level), 32'h4);
      applyStimulus(4'b1111);
      stepClock(10);
      checkOutput("bounceRelLevel", 32'(Level), 32'h0);

      // Simultaneous falling on ch1 and ch3
      applyStimulus(4'b0101);
      stepClock(5);
      checkOutput("simEarly", 32'(Press), 32'h0);
      stepClock(1);
      checkOutput("simPress", 32'(Press), 32'hA);
      checkOutput("simLevel", 32'(Level), 32'hA);
      applyStimulus(4'b1111);
      stepClock(10);
      checkOutput("simRelLevel", 32'(Level), 32'h0);

      // Reset mid-debounce on ch0, counter must restart from scratch
      applyStimulus(4'b1110);
      stepClock(4);
      checkOutput("midLevel", 32'(Level), 32'h0);
      nReset = 1'b0;
      #2;
      checkOutput("midRstLevel", 32'(Level), 32'h0);
      checkOutput("midRstPress", 32'(Press), 32'h0);
      nReset = 1'b1;
      stepClock(5);
      checkOutput("postRstEarly", 32'(Press), 32'h0);
      stepClock(1);
      checkOutput("postRstPress", 32'(Press), 32'h1);
      applyStimulus(4'b1111);
      stepClock(10);
      checkOutput("postRstRel", 32'(Level), 32'h0);

      // Long hold on ch1
      pressTick = -1;
      longTick  = -1;
      longCount = 0;
      applyStimulus(4'b1101);
      for (int j = 0; j < 40; j++) begin
         stepClock(1);
         if (Press[1] && pressTick < 0) pressTick = j;
         if (LongPress[1]) begin
            longCount++;
            if (longTick < 0) longTick = j;
         end
      end
      checkOutput("holdPressTick", 32'(pressTick), 32'd5);
`ifdef LONG_PRESS_EN
      checkOutput("longCount", 32'(longCount), 32'd1);
      checkOutput("longTick", 32'(longTick), 32'd21);
`else
      checkOutput("longCount", 32'(longCount), 32'd0);
      checkOutput("longNever", 32'(sawLong), 32'd0);
`endif
      applyStimulus(4'b1111);
      stepClock(8);
      checkOutput("finalLevel", 32'(Level), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
